// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider / tick generator with runtime divisor updates via a valid/ready port.
// Optional CLKDIV_RESYNC_EN adds a resync input that zeroes all phases and applies pending divisors.
module clkdiv_multi #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 28,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {28'd2500000, 28'd5000000}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] en,
  // Handshake: a divisor transfers on any CLK edge where cfg_valid && cfg_ready;
  // cfg_ready depends only on RST, cfg_ch and the target's pending flag.
  input  logic              cfg_valid,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
`ifdef CLKDIV_RESYNC_EN
  input  logic              resync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  div_q    [NUM_CH];
  logic [CNT_W-1:0]  div_d    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] xfer, run, at_edge;
  logic              ready_sel;

  // Out-of-range channel indices never match, so the request simply stalls.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == 3'(i) && !pend_q[i]) ready_sel = 1'b1;
    end
  end

  assign cfg_ready = !RST && ready_sel;

  always_comb begin
    xfer    = '0;
    run     = '0;
    at_edge = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      xfer[i]    = cfg_valid && cfg_ready && (cfg_ch == 3'(i));
      run[i]     = en[i] && (div_q[i] != '0);
      at_edge[i] = cnt_q[i] == (div_q[i] - CNT_W'(1));
    end
  end

  always_comb begin
    clk_d  = clk_q;
    tick_d = '0;
    pend_d = pend_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      div_d[i]    = div_q[i];
      shadow_d[i] = shadow_q[i];
      if (xfer[i]) begin
        shadow_d[i] = cfg_div;
        pend_d[i]   = 1'b1;
      end
      if (!run[i]) begin
        if (div_q[i] == '0) begin
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
        end
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          cnt_d[i]  = '0;
          pend_d[i] = 1'b0;
        end
      end else if (at_edge[i]) begin
        // The half-period finishes on the old divisor; a new one takes over from here.
        cnt_d[i]  = '0;
        clk_d[i]  = ~clk_q[i];
        tick_d[i] = ~clk_q[i];
        if (pend_q[i]) begin
          div_d[i]  = shadow_q[i];
          pend_d[i] = 1'b0;
          if (shadow_q[i] == '0) begin
            clk_d[i]  = 1'b0;
            tick_d[i] = 1'b0;
          end
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
`ifdef CLKDIV_RESYNC_EN
      if (resync) begin
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        tick_d[i] = 1'b0;
        if (xfer[i])       div_d[i] = cfg_div;
        else if (pend_q[i]) div_d[i] = shadow_q[i];
        pend_d[i] = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      clk_q  <= '0;
      tick_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= DIV_INIT[i*CNT_W +: CNT_W];
        shadow_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
      end
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_q[i]    <= div_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi (NUM_CH=2, CNT_W=8, divisors 3/5); cycle k is sampled 1 time unit after the k-th edge following reset release.
module tb_clkdiv_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] en;
  logic       cfg_valid;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic [1:0] clk_out;
  logic [1:0] tick;
`ifdef CLKDIV_RESYNC_EN
  logic       resync;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] en;
    logic [1:0] exp_clk;
    logic [1:0] exp_tick;
  } vec_t;
  vec_t vecs[21];

  clkdiv_multi #(.NUM_CH(2), .CNT_W(8), .DIV_INIT({8'd5, 8'd3})) dut (
    .CLK(CLK),
    .RST(RST),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_ready(cfg_ready),
`ifdef CLKDIV_RESYNC_EN
    .resync(resync),
`endif
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  task automatic run_table(input int n);
    for (int k = 0; k < n; k++) begin
      en = vecs[k].en;
      if (k > 0) next_cycle();
      chk($sformatf("tbl_clk c%0d", k), clk_out, vecs[k].exp_clk);
      chk($sformatf("tbl_tick c%0d", k), tick, vecs[k].exp_tick);
    end
  endtask

  initial begin
    logic [20:0] clk0_pat, tick0_pat, clk1_pat, tick1_pat;
    logic [7:0]  pa_clk, pa_tick, pb_clk;
    logic [15:0] pc_clk;

    RST = 1'b1; en = 2'b11; cfg_valid = 1'b0; cfg_ch = 3'd0; cfg_div = 8'd0;
`ifdef CLKDIV_RESYNC_EN
    resync = 1'b0;
`endif
    // Hand-derived waveforms for divisors 3 and 5, bit index = cycle.
    clk0_pat  = 21'b000_111_000_111_000_111_000;
    tick0_pat = 21'b000_001_000_001_000_001_000;
    clk1_pat  = 21'b0_11111_00000_11111_00000;
    tick1_pat = 21'b0_00001_00000_00001_00000;
    for (int k = 0; k < 21; k++) begin
      vecs[k].en       = 2'b11;
      vecs[k].exp_clk  = {clk1_pat[k], clk0_pat[k]};
      vecs[k].exp_tick = {tick1_pat[k], tick0_pat[k]};
    end

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    cfg_valid = 1'b1;
    chk("rst_clk", clk_out, 2'b00);
    chk("rst_tick", tick, 2'b00);
    chk("rst_ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", cfg_ready, 1'b1);
    run_table(21);

    // Asynchronous reset in the middle of a high phase
    next_cycle();
    chk("pre_async_clk0", clk_out[0], 1'b1);
    RST = 1'b1;
    #1;
    chk("async_rst_clk", clk_out, 2'b00);
    chk("async_rst_tick", tick, 2'b00);
    chk("async_rst_ready", cfg_ready, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    run_table(12);

    // Lower ch0 to 2 mid half-period; a second write stalls while pending
    do_reset();
    next_cycle();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
    chk("a_ready_c1", cfg_ready, 1'b1);
    next_cycle();
    cfg_div = 8'd7;
    chk("a_stall_c2", cfg_ready, 1'b0);
    next_cycle();
    chk("a_ready_c3", cfg_ready, 1'b1);
    cfg_valid = 1'b0;
    pa_clk  = 8'b0011_0011;
    pa_tick = 8'b0001_0001;
    for (int k = 3; k <= 10; k++) begin
      if (k > 3) next_cycle();
      chk($sformatf("a_clk0 c%0d", k), clk_out[0], pa_clk[k-3]);
      chk($sformatf("a_tick0 c%0d", k), tick[0], pa_tick[k-3]);
    end

    // Transfer on the same cycle as a ch0 toggle: applied at the following toggle
    do_reset();
    next_cycle();
    next_cycle();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
    next_cycle();
    chk("b_pending_c3", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    pb_clk = 8'b0110_0111;
    for (int k = 3; k <= 10; k++) begin
      if (k > 3) next_cycle();
      chk($sformatf("b_clk0 c%0d", k), clk_out[0], pb_clk[k-3]);
    end

    // en[1] low for 4 cycles stretches the high phase to 9 cycles
    do_reset();
    pc_clk = 16'b0011_1111_1110_0000;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      chk($sformatf("c_clk1 c%0d", k), clk_out[1], pc_clk[k]);
      chk($sformatf("c_tick1 c%0d", k), tick[1], (k == 5) ? 1'b1 : 1'b0);
      if (k == 6) en = 2'b01;
      if (k == 10) en = 2'b11;
    end

    // ch1 divisor 0 stops it at the boundary; divisor 4 then restarts it
    do_reset();
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd0;
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      cfg_valid = 1'b0;
      chk($sformatf("d_clk1 c%0d", k), clk_out[1], 1'b0);
      chk($sformatf("d_tick1 c%0d", k), tick[1], 1'b0);
    end
    cfg_valid = 1'b1; cfg_div = 8'd4;
    chk("d_ready_c12", cfg_ready, 1'b1);
    next_cycle();
    chk("d_pending_c13", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    for (int k = 13; k <= 19; k++) begin
      if (k > 13) next_cycle();
      chk($sformatf("d2_clk1 c%0d", k), clk_out[1], (k >= 18) ? 1'b1 : 1'b0);
      chk($sformatf("d2_tick1 c%0d", k), tick[1], (k == 18) ? 1'b1 : 1'b0);
    end

    // Out-of-range channel index is never ready
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd1;
    #1;
    chk("e_ready_ch2", cfg_ready, 1'b0);
    cfg_ch = 3'd7;
    #1;
    chk("e_ready_ch7", cfg_ready, 1'b0);
    cfg_ch = 3'd1;
    #1;
    chk("e_ready_ch1", cfg_ready, 1'b1);
    cfg_valid = 1'b0;

`ifdef CLKDIV_RESYNC_EN
    // Resync aligns both channels; resync with a transfer applies the new divisor at once
    do_reset();
    repeat (7) next_cycle();
    resync = 1'b1;
    for (int k = 8; k <= 13; k++) begin
      next_cycle();
      resync = 1'b0;
      chk($sformatf("f_clk0 c%0d", k), clk_out[0], (k >= 11) ? 1'b1 : 1'b0);
      chk($sformatf("f_clk1 c%0d", k), clk_out[1], (k == 13) ? 1'b1 : 1'b0);
      chk($sformatf("f_tick c%0d", k), tick, {(k == 13) ? 1'b1 : 1'b0, (k == 11) ? 1'b1 : 1'b0});
    end
    resync = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd2;
    next_cycle();
    resync = 1'b0; cfg_valid = 1'b0;
    chk("g_clk_c14", clk_out, 2'b00);
    chk("g_ready_c14", cfg_ready, 1'b1);
    next_cycle();
    chk("g_clk0_c15", clk_out[0], 1'b0);
    next_cycle();
    chk("g_clk0_c16", clk_out[0], 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
